// File: rtl/ws2812_encoder_pkg.sv
// Shared types and default timing for the WS2812 serial transmit path.
package ws2812_encoder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BIT   = 2'd1,
      LATCH = 2'd2
   } encoder_state_t;

   typedef struct packed {
      logic [23:0] data;
      logic        last;
   } pixel_t;

   localparam pixel_t RESET_VALUES_PIXEL = '{data: 24'h000000, last: 1'b0};

   localparam int DEF_T0H_CYC    = 20;
   localparam int DEF_T1H_CYC    = 40;
   localparam int DEF_TBIT_CYC   = 62;
   localparam int DEF_TRESET_CYC = 2600;

endpackage

// File: rtl/encoder_bit_timer.sv
// Times one NRZ bit period and produces the registered line level for it.
module encoder_bit_timer #(
   parameter int T0H_CYC  = 20,
   parameter int T1H_CYC  = 40,
   parameter int TBIT_CYC = 62
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_i,
   input  logic bit_i,
   output logic level_o,
   output logic end_o
);

   localparam logic [9:0] TBIT_M1 = 10'(TBIT_CYC - 1);
   localparam logic [9:0] T0H     = 10'(T0H_CYC);
   localparam logic [9:0] T1H     = 10'(T1H_CYC);

   logic [9:0] bit_cnt_q;
   logic [9:0] th_q;
   logic       run_q;
   logic       level_q;
   logic [9:0] cnt_inc;

   assign cnt_inc = bit_cnt_q + 10'd1;
   assign end_o   = run_q && (bit_cnt_q == TBIT_M1);
   assign level_o = level_q;

   // start wins over end so consecutive bits abut with no idle cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_q <= '0;
         th_q      <= '0;
         run_q     <= 1'b0;
         level_q   <= 1'b0;
      end else if (start_i) begin
         bit_cnt_q <= '0;
         th_q      <= bit_i ? T1H : T0H;
         run_q     <= 1'b1;
         level_q   <= 1'b1;
      end else if (end_o) begin
         bit_cnt_q <= '0;
         run_q     <= 1'b0;
         level_q   <= 1'b0;
      end else if (run_q) begin
         bit_cnt_q <= cnt_inc;
         level_q   <= (cnt_inc < th_q);
      end
   end

endmodule

// File: rtl/ws2812_encoder.sv
// WS2812 NRZ transmitter: takes GRB pixels over valid/ready and drives the serial line.
module ws2812_encoder
   import ws2812_encoder_pkg::*;
#(
   parameter int T0H_CYC    = DEF_T0H_CYC,
   parameter int T1H_CYC    = DEF_T1H_CYC,
   parameter int TBIT_CYC   = DEF_TBIT_CYC,
   parameter int TRESET_CYC = DEF_TRESET_CYC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] pixel_data,
   input  logic        pixel_last,
   input  logic        pixel_valid,
   output logic        pixel_ready,
   output logic        dout,
   output logic        busy,
   output logic        underflow
);

   localparam int             RW      = $clog2(TRESET_CYC + 1);
   localparam logic [RW-1:0]  TRST_M1 = RW'(TRESET_CYC - 1);

   if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC && TBIT_CYC <= 1023))
   begin : g_bad_bit_timing
      $error("ws2812_encoder: need 0 < T0H_CYC < T1H_CYC < TBIT_CYC <= 1023");
   end
   if (TRESET_CYC < 1) begin : g_bad_reset_timing
      $error("ws2812_encoder: TRESET_CYC must be at least 1");
   end

   encoder_state_t state_q, state_d;
   pixel_t         pix_q, pix_d;
   logic [4:0]     bit_idx_q, bit_idx_d;
   logic [RW-1:0]  rst_cnt_q, rst_cnt_d;
   logic           underflow_q, underflow_d;
   logic           bit_end, start, start_bit, xfer, last_bit;

   encoder_bit_timer #(
      .T0H_CYC  (T0H_CYC),
      .T1H_CYC  (T1H_CYC),
      .TBIT_CYC (TBIT_CYC)
   ) u_bit_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start),
      .bit_i   (start_bit),
      .level_o (dout),
      .end_o   (bit_end)
   );

   always_comb begin
      last_bit    = (bit_idx_q == 5'd0);
      pixel_ready = (state_q == IDLE) ||
                    ((state_q == BIT) && bit_end && last_bit && !pix_q.last);
      xfer        = pixel_valid && pixel_ready;
      state_d     = state_q;
      pix_d       = pix_q;
      bit_idx_d   = bit_idx_q;
      rst_cnt_d   = rst_cnt_q;
      underflow_d = 1'b0;
      start       = 1'b0;
      start_bit   = 1'b0;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               pix_d     = '{data: pixel_data, last: pixel_last};
               bit_idx_d = 5'd23;
               state_d   = BIT;
               start     = 1'b1;
               start_bit = pixel_data[23];
            end
         end
         BIT: begin
            if (bit_end) begin
               if (!last_bit) begin
                  pix_d.data = pix_q.data << 1;
                  bit_idx_d  = bit_idx_q - 5'd1;
                  start      = 1'b1;
                  start_bit  = pix_q.data[22];
               end else if (pix_q.last) begin
                  state_d   = LATCH;
                  rst_cnt_d = '0;
               end else if (xfer) begin
                  // seamless reload: next pixel's MSB starts on the very next cycle
                  pix_d     = '{data: pixel_data, last: pixel_last};
                  bit_idx_d = 5'd23;
                  start     = 1'b1;
                  start_bit = pixel_data[23];
               end else begin
                  state_d     = IDLE;
                  underflow_d = 1'b1;
               end
            end
         end
         LATCH: begin
            if (rst_cnt_q == TRST_M1) begin
               state_d   = IDLE;
               rst_cnt_d = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pix_q       <= RESET_VALUES_PIXEL;
         bit_idx_q   <= '0;
         rst_cnt_q   <= '0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pix_q       <= pix_d;
         bit_idx_q   <= bit_idx_d;
         rst_cnt_q   <= rst_cnt_d;
         underflow_q <= underflow_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign underflow = underflow_q;

endmodule

// File: tb/tb_ws2812_encoder.sv
// Randomized bench for ws2812_encoder: cycle-level expected waveform plus a pulse-width decoder loopback.
`timescale 1ns/1ps
module tb_ws2812_encoder;
   import ws2812_encoder_pkg::*;

   localparam int T0H = 20, T1H = 40, TBIT = 62, TRST = 2600, PAD = 6;
   localparam int PIX = 24 * TBIT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] pixel_data = '0;
   logic        pixel_last = 1'b0;
   logic        pixel_valid = 1'b0;
   logic        pixel_ready, dout, busy, underflow;

   always #5 clk = ~clk;

   ws2812_encoder #(
      .T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT), .TRESET_CYC(TRST)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pixel_data(pixel_data), .pixel_last(pixel_last),
      .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .dout(dout),
      .busy(busy), .underflow(underflow)
   );

   int n_asrt = 0, n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_asrt++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // capture of DUT outputs, one entry per cycle, sampled mid-cycle
   logic cap = 1'b0;
   int   cap_len = 0;
   logic m_dout[$], m_busy[$], m_rdy[$], m_uf[$];
   always @(negedge clk) begin
      if (cap && m_dout.size() < cap_len) begin
         m_dout.push_back(dout);
         m_busy.push_back(busy);
         m_rdy.push_back(pixel_ready);
         m_uf.push_back(underflow);
      end
   end

   // reference timeline built from the pixel list
   pixel_t seq[$];
   logic   e_dout[$], e_busy[$], e_rdy[$], e_uf[$];

   task automatic exp_push(input logic d, input logic b, input logic r, input logic u);
      e_dout.push_back(d);
      e_busy.push_back(b);
      e_rdy.push_back(r);
      e_uf.push_back(u);
   endtask

   task automatic build_expected();
      e_dout.delete(); e_busy.delete(); e_rdy.delete(); e_uf.delete();
      exp_push(1'b0, 1'b0, 1'b1, 1'b0);
      foreach (seq[k]) begin
         for (int b = 23; b >= 0; b--) begin
            int th;
            th = seq[k].data[b] ? T1H : T0H;
            for (int c = 0; c < TBIT; c++)
               exp_push(c < th, 1'b1, (b == 0 && c == TBIT - 1 && !seq[k].last), 1'b0);
         end
         if (seq[k].last) begin
            for (int c = 0; c < TRST; c++) exp_push(1'b0, 1'b1, 1'b0, 1'b0);
            exp_push(1'b0, 1'b0, 1'b1, 1'b0);
         end else if (k == seq.size() - 1) begin
            exp_push(1'b0, 1'b0, 1'b1, 1'b1);
         end
      end
      for (int c = 0; c < PAD; c++) exp_push(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   // offers each pixel in turn, holding valid until it is taken
   task automatic drive_seq();
      foreach (seq[k]) begin
         int   t;
         logic r;
         t = 0;
         pixel_data  = seq[k].data;
         pixel_last  = seq[k].last;
         pixel_valid = 1'b1;
         do begin
            @(negedge clk);
            r = pixel_ready;
            t++;
            @(posedge clk);
            #1;
         end while (!r && t < 20000);
         if (!r) check_eq("accept_timeout", 32'd0, 32'd1);
      end
      pixel_valid = 1'b0;
   endtask

   task automatic decode_check(input string name);
      logic [23:0] w;
      logic        prev;
      int          nb, hl, ll, nres, nw, werr, nlast;
      w = '0; prev = 1'b0; nb = 0; hl = 0; ll = 0; nres = 0; nw = 0; werr = 0; nlast = 0;
      foreach (m_dout[i]) begin
         if (m_dout[i]) begin
            hl++;
            ll = 0;
         end else begin
            if (prev) begin
               w  = {w[22:0], (hl > (T0H + T1H) / 2)};
               nb++;
               hl = 0;
               if (nb == 24) begin
                  if (nw >= seq.size() || w !== seq[nw].data) werr++;
                  nw++;
                  nb = 0;
               end
            end
            ll++;
            if (ll == TRST) nres++;
         end
         prev = m_dout[i];
      end
      foreach (seq[k]) if (seq[k].last) nlast++;
      check_eq({name, "_dec_words"}, nw, seq.size());
      check_eq({name, "_dec_errs"}, werr, 0);
      check_eq({name, "_treset"}, nres, nlast);
   endtask

   task automatic run_seq(input string name);
      int t, ed, eb, er, eu;
      build_expected();
      m_dout.delete(); m_busy.delete(); m_rdy.delete(); m_uf.delete();
      cap_len = e_dout.size();
      cap = 1'b1;
      drive_seq();
      t = 0;
      while (m_dout.size() < cap_len && t < 30000) begin
         @(posedge clk);
         t++;
      end
      #1;
      cap = 1'b0;
      check_eq({name, "_len"}, m_dout.size(), cap_len);
      ed = 0; eb = 0; er = 0; eu = 0;
      foreach (m_dout[i]) begin
         if (m_dout[i] !== e_dout[i]) ed++;
         if (m_busy[i] !== e_busy[i]) eb++;
         if (m_rdy[i]  !== e_rdy[i])  er++;
         if (m_uf[i]   !== e_uf[i])   eu++;
      end
      check_eq({name, "_dout_errs"}, ed, 0);
      check_eq({name, "_busy_errs"}, eb, 0);
      check_eq({name, "_ready_errs"}, er, 0);
      check_eq({name, "_underflow_errs"}, eu, 0);
      decode_check(name);
   endtask

   function automatic int count_ones(input int lo, input int hi, input int which);
      int n;
      n = 0;
      for (int i = lo; i <= hi && i < m_dout.size(); i++) begin
         case (which)
            0: n += int'(m_dout[i]);
            1: n += int'(m_busy[i]);
            2: n += int'(m_rdy[i]);
            default: n += int'(m_uf[i]);
         endcase
      end
      return n;
   endfunction

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_dout", dout, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_ready", pixel_ready, 1'b1);
      check_eq("rst_underflow", underflow, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      seq.delete();
      seq.push_back('{data: 24'hFF0000, last: 1'b1});
      run_seq("single");
      check_eq("single_busy_cycles", count_ones(0, cap_len - 1, 1), PIX + TRST);
      check_eq("single_busy_after_latch", m_busy[1 + PIX + TRST], 1'b0);

      seq.delete();
      seq.push_back('{data: 24'hAAAAAA, last: 1'b0});
      seq.push_back('{data: 24'h555555, last: 1'b1});
      run_seq("two_pix");
      check_eq("two_pix_ready_cycles", count_ones(1, 2 * PIX, 2), 1);
      check_eq("two_pix_busy_cycles", count_ones(0, cap_len - 1, 1), 2 * PIX + TRST);

      seq.delete();
      seq.push_back('{data: 24'h000001, last: 1'b0});
      run_seq("starve");
      check_eq("starve_uf_pulses", count_ones(0, cap_len - 1, 3), 1);
      check_eq("starve_busy_cycles", count_ones(0, cap_len - 1, 1), PIX);
      check_eq("starve_last_high", count_ones(PIX - TBIT + 1, PIX, 0), T1H);

      seq.delete();
      seq.push_back('{data: 24'($urandom), last: 1'b1});
      seq.push_back('{data: 24'($urandom), last: 1'b1});
      run_seq("latch_pend");
      check_eq("latch_pend_ready_in_latch", count_ones(1 + PIX, PIX + TRST, 2), 0);
      check_eq("latch_pend_accept_cycle", m_rdy[1 + PIX + TRST], 1'b1);
      check_eq("latch_pend_rise", m_dout[2 + PIX + TRST], 1'b1);

      // reset in the middle of bit 12, cycle 30
      pixel_data  = 24'($urandom);
      pixel_last  = 1'b1;
      pixel_valid = 1'b1;
      @(posedge clk);
      #1;
      pixel_valid = 1'b0;
      repeat (11 * TBIT + 30 - 1) @(posedge clk);
      #1;
      check_eq("mid_busy_before_rst", busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_dout", dout, 1'b0);
      check_eq("mid_rst_busy", busy, 1'b0);
      check_eq("mid_rst_ready", pixel_ready, 1'b1);
      check_eq("mid_rst_underflow", underflow, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("post_rst_idle_busy", busy, 1'b0);
      seq.delete();
      seq.push_back('{data: 24'($urandom), last: 1'b1});
      run_seq("post_rst");

      for (int f = 0; f < 3; f++) begin
         int n;
         n = int'($urandom_range(1, 3));
         seq.delete();
         for (int k = 0; k < n; k++) seq.push_back('{data: 24'($urandom), last: (k == n - 1)});
         run_seq($sformatf("rand%0d", f));
      end

      seq.delete();
      seq.push_back('{data: 24'($urandom), last: 1'b0});
      run_seq("rand_starve");

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
